// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_e : fetch FSM state encoding (2 bits)
//   pc_sel_e      : PC register update select
//   RESET_PC_DEFAULT, NOP_INSTR : default reset PC and the "empty" instruction word
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 16;
  localparam int unsigned INSTR_W_DEFAULT = 16;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] NOP_INSTR        = 16'h0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold / load / increment select.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (loads RESET_PC)
//   sel_i        : PC_HOLD keeps, PC_LOAD takes load_pc_i, PC_INC adds 1 (mod 2^ADDR_W)
//   load_pc_i    : value loaded on PC_LOAD
//   pc_o         : current PC
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC; the increment wraps naturally at the register width.
  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_LOAD: pc_d = load_pc_i;
      PC_INC:  pc_d = pc_q + ADDR_W'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one instruction-memory request at a
// time at the current PC, hands the returned word to decode under a
// valid/ready handshake, and honours branch/jump redirects by discarding
// any response still in flight.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   imem_req, imem_addr      : request strobe and word address (from state and PC only)
//   imem_rvalid, imem_rdata  : memory response
//   id_valid, id_instr, id_pc: registered instruction/PC presented to decode
//   id_ready                 : decode accepts the presented instruction
//   redirect, redirect_pc    : taken branch/jump and its target
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned       INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  fetch_state_e       state_q;
  logic               kill_q;
  logic               id_valid_q;
  logic [INSTR_W-1:0] id_instr_q;
  logic [ADDR_W-1:0]  id_pc_q;
  logic [ADDR_W-1:0]  pc_q;
  pc_sel_e            pc_sel;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .sel_i     (pc_sel),
    .load_pc_i (redirect_pc),
    .pc_o      (pc_q)
  );

  // PC update: a redirect always wins; the PC advances only when decode
  // takes the held instruction.
  always_comb begin
    pc_sel = PC_HOLD;
    case (state_q)
      S_REQ, S_WAIT: begin
        if (redirect) pc_sel = PC_LOAD;
      end
      S_HOLD: begin
        if (redirect)      pc_sel = PC_LOAD;
        else if (id_ready) pc_sel = PC_INC;
      end
      default: pc_sel = PC_HOLD;
    endcase
  end

  // Fetch FSM, kill flag and decode-side output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      kill_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= INSTR_W'(NOP_INSTR);
      id_pc_q    <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          state_q <= S_WAIT;
          // The request just issued targets the old PC; drop its response.
          if (redirect) kill_q <= 1'b1;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!kill_q && !redirect) begin
              id_instr_q <= imem_rdata;
              id_pc_q    <= pc_q;
              id_valid_q <= 1'b1;
              state_q    <= S_HOLD;
            end else begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || id_ready) begin
            id_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

  // Request is a pure function of state; reset only masks the strobe.
  assign imem_req  = (state_q == S_REQ) && !reset;
  assign imem_addr = pc_q;

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven startup/backpressure
// vectors plus hand-written redirect, wrap and reset sequences against a
// simple latency-programmable instruction memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;

  int n_chk  = 0;
  int n_fail = 0;

  // memory model state
  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = '0;
  logic [15:0] req_q[$];

  instr_fetch #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one cycle: drive this cycle's inputs, then let the memory model
  // see this cycle's request and produce its response.
  task automatic cyc(input logic rst, input logic rdy, input logic rd, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    reset       = rst;
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    imem_rvalid = 1'b0;
    if (rst) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = {mem_addr[7:0], 8'hA5};
          mem_pend    = 1'b0;
        end
      end
      if (imem_req) begin
        mem_pend = 1'b1;
        mem_cnt  = lat;
        mem_addr = imem_addr;
        req_q.push_back(imem_addr);
      end
    end
    #1;
  endtask

  task automatic exp_req(input string nm, input logic [15:0] addr);
    chk({nm, "_req"}, 32'(imem_req), 32'd1);
    chk({nm, "_addr"}, 32'(imem_addr), 32'(addr));
  endtask

  task automatic exp_out(input string nm, input logic v, input logic [15:0] pc, input logic [15:0] ins);
    chk({nm, "_valid"}, 32'(id_valid), 32'(v));
    if (v) begin
      chk({nm, "_pc"}, 32'(id_pc), 32'(pc));
      chk({nm, "_instr"}, 32'(id_instr), 32'(ins));
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int hits;

    // startup with 1-cycle memory, then 5 cycles of backpressure
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h00A5};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h01A5};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    for (int i = 9; i < 14; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h02A5};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h02A5};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000};

    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].rst, vecs[i].rdy, 1'b0, 16'h0000);
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        chk($sformatf("row%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      exp_out($sformatf("row%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
    end

    // Redirect in S_WAIT with a 3-cycle memory: stale response dropped.
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    lat = 3;
    req_q.delete();
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c0: REQ @0
    exp_req("rw_c0", 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0040);            // c1: WAIT, redirect
    chk("rw_c1_req", 32'(imem_req), 32'd0);
    exp_out("rw_c1", 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c2: WAIT
    exp_out("rw_c2", 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c3: stale rvalid
    chk("rw_c3_stale_rvalid", 32'(imem_rvalid), 32'd1);
    exp_out("rw_c3", 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c4: REQ @0x40
    exp_req("rw_c4", 16'h0040);
    exp_out("rw_c4", 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c7: rvalid
    exp_out("rw_c7", 1'b0, 16'h0, 16'h0);

    // Redirect in S_HOLD together with id_ready: held instruction dropped.
    cyc(1'b0, 1'b1, 1'b1, 16'h0100);            // c8: HOLD
    exp_out("rh_c8", 1'b1, 16'h0040, 16'h40A5);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c9: REQ @0x100
    exp_req("rh_c9", 16'h0100);
    exp_out("rh_c9", 1'b0, 16'h0, 16'h0);
    hits = 0;
    foreach (req_q[k]) if (req_q[k] == 16'h0041) hits++;
    chk("rh_no_req_pc_plus1", 32'(hits), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c12: rvalid

    // Wrap: redirect to 0xFFFF, accept, next request at 0x0000.
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFF);            // c13: HOLD
    exp_out("wr_c13", 1'b1, 16'h0100, 16'h00A5);
    lat = 1;
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c14: REQ @FFFF
    exp_req("wr_c14", 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c15: WAIT rvalid
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);            // c16: HOLD, accept
    exp_out("wr_c16", 1'b1, 16'hFFFF, 16'hFFA5);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c17: REQ @0
    exp_req("wr_c17", 16'h0000);

    // Reset in S_WAIT.
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);            // c18
    chk("rst_wait_c18_req", 32'(imem_req), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);            // c19
    chk("rst_wait_c19_req", 32'(imem_req), 32'd0);
    exp_out("rst_wait_c19", 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c20: restart
    exp_req("rst_wait_c20", 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c21: WAIT rvalid
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);            // c22: HOLD
    exp_out("rst_hold_c22", 1'b1, 16'h0000, 16'h00A5);

    // Reset in S_HOLD.
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);            // c23
    chk("rst_hold_c23_req", 32'(imem_req), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);            // c24
    chk("rst_hold_c24_req", 32'(imem_req), 32'd0);
    exp_out("rst_hold_c24", 1'b0, 16'h0, 16'h0);
    chk("rst_hold_c24_idpc", 32'(id_pc), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);            // c25: restart
    exp_req("rst_hold_c25", 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
